skitter_edge_stats: RTL and testbench
=====================================

Name: skitter_edge_stats

Overview:
- Downstream consumer of the skitter encoder's 6-bit edge-position code, running alongside the histogram.
- Over a programmable window of valid edge samples it computes min, max, peak-to-peak and mean edge position, and counts no-edge samples.
- Gives a compact per-window jitter summary for readout without scanning the histogram bins.
- Armed by a start pulse; reports completion with a one-cycle done pulse.

Parameters:
- POS_W, 6, width of the edge-position code from the encoder.
- WIN_LOG2, 8, log2 of the window length in valid samples (window = 2^WIN_LOG2).
- MISS_W, 8, width of the saturating no-edge counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pos_in  in  POS_W  edge-position code from the encoder; value 0 = no edge found.
- sample_en  in  1  pos_in is sampled this cycle when high.
- start  in  1  pulse: clear accumulators and begin a window.
- abort  in  1  pulse: cancel the current window.
- busy  out  1  high while a window is accumulating.
- done  out  1  one-cycle pulse when results update.
- min_pos  out  POS_W  smallest valid position in the last window.
- max_pos  out  POS_W  largest valid position in the last window.
- p2p  out  POS_W  max_pos - min_pos.
- mean_pos  out  POS_W  floor(sum / 2^WIN_LOG2).
- miss_cnt  out  MISS_W  no-edge samples seen during the last window, saturating.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, min_pos, max_pos, p2p, mean_pos and miss_cnt all 0; internal sum, window count and first-sample flag all 0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and abort=0 -> ACCUM; clear sum, window count and internal miss count; set first-sample flag.
  - Output registers hold their previous values.
- ACCUM (busy=1), on each cycle with sample_en=1:
  - pos_in==0: internal miss count increments, saturating at all-ones; window count does not advance.
  - pos_in!=0: sum += pos_in; window count increments.
  - First valid sample of the window loads both running min and running max.
  - Later samples update min/max with strict compares.
- ACCUM exit: the edge that accepts valid sample number 2^WIN_LOG2 moves to DONE.
- DONE, for one cycle:
  - Outputs register from the running values; mean = sum >> WIN_LOG2, truncated.
  - done=1 and busy=0 during this cycle, then -> IDLE.
  - Latency: done is high in the cycle after the edge that accepted the last sample.
- Sum width is POS_W+WIN_LOG2 and cannot overflow; p2p never goes negative.
- abort=1 in ACCUM -> IDLE next edge; outputs unchanged; no done pulse.
- start and abort both high in IDLE: abort wins, stay IDLE.
- start while in ACCUM or DONE is ignored.
- sample_en=0 cycles are ignored; a window may stretch indefinitely, so the host uses abort as its timeout.
- Reset mid-window clears everything, as at power-on.

Optional Feature:
- Macro: SKITTER_STATS_SUMSQ_EN.
- Defined:
  - Adds output sumsq, width 2*POS_W+WIN_LOG2: sum of pos_in^2 over the valid samples.
  - Registered in DONE with the other results and reset to 0.
  - Lets software compute variance.
- Undefined: the port and the squaring logic are absent; all other behaviour is identical.

Decomposition:
- Shared package skitter_pkg:
  - POS_W default.
  - NO_EDGE constant (0).
  - State typedef (IDLE, ACCUM, DONE).
- One natural sub-module: skitter_minmax_trk, holding the running min/max registers with first-sample load and strict-compare update.

Test Plan (WIN_LOG2=2 unless stated):
- Reset then start; samples 20,25,18,30 with sample_en=1 -> done one cycle after the 4th; min=18, max=30, p2p=12, mean=23, miss=0.
- Start; samples 22,0,0,22,22,22 -> done after the 6th sample; min=max=22, p2p=0, mean=22, miss=2.
- MISS_W=2; start; five 0-samples then 17,17,17,17 -> miss=3 (saturated); mean=17.
- Start; 20,21 then abort -> IDLE, no done, outputs keep the previous window's values; a following start+abort in the same cycle stays IDLE.
- Start; 38,38 then rst low -> all outputs 0 immediately; busy=0.
- With SKITTER_STATS_SUMSQ_EN: samples 1,2,3,4 -> sumsq=30, mean=2.

Source files
------------

// File: rtl/skitter_pkg.sv
// Shared definitions for the skitter edge-statistics slice: default code width,
// the no-edge code and the window FSM state encoding.
package skitter_pkg;

    localparam int POS_W_DEF = 6;
    localparam int NO_EDGE   = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/skitter_minmax_trk.sv
// Running min/max tracker: first valid sample loads both, later samples
// replace them only on strictly smaller/larger values.
module skitter_minmax_trk #(
    parameter int POS_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             upd,
    input  logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] min_nxt,
    output logic [POS_W-1:0] max_nxt
);

    logic             first_r;
    logic [POS_W-1:0] min_r;
    logic [POS_W-1:0] max_r;

    // Next running extremes, including the sample being accepted this cycle
    always_comb begin
        min_nxt = min_r;
        max_nxt = max_r;
        if (upd) begin
            if (first_r) begin
                min_nxt = pos;
                max_nxt = pos;
            end else begin
                if (pos < min_r) begin
                    min_nxt = pos;
                end else begin
                    min_nxt = min_r;
                end
                if (pos > max_r) begin
                    max_nxt = pos;
                end else begin
                    max_nxt = max_r;
                end
            end
        end else begin
            min_nxt = min_r;
            max_nxt = max_r;
        end
    end

    // Running min/max registers and first-sample flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_r <= 1'b0;
            min_r   <= {POS_W{1'b0}};
            max_r   <= {POS_W{1'b0}};
        end else if (clear) begin
            first_r <= 1'b1;
            min_r   <= {POS_W{1'b0}};
            max_r   <= {POS_W{1'b0}};
        end else if (upd) begin
            first_r <= 1'b0;
            min_r   <= min_nxt;
            max_r   <= max_nxt;
        end
    end

endmodule

// File: rtl/skitter_edge_stats.sv
// Per-window jitter summary (min/max/p2p/mean/miss) of skitter edge codes.
// Optional sum-of-squares output enabled by SKITTER_STATS_SUMSQ_EN.
module skitter_edge_stats
    import skitter_pkg::*;
#(
    parameter int POS_W    = POS_W_DEF,
    parameter int WIN_LOG2 = 8,
    parameter int MISS_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [POS_W-1:0]  pos_in,
    input  logic              sample_en,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  min_pos,
    output logic [POS_W-1:0]  max_pos,
    output logic [POS_W-1:0]  p2p,
    output logic [POS_W-1:0]  mean_pos,
`ifdef SKITTER_STATS_SUMSQ_EN
    output logic [2*POS_W+WIN_LOG2-1:0] sumsq,
`endif
    output logic [MISS_W-1:0] miss_cnt
);

    localparam int SUM_W = POS_W + WIN_LOG2;

    state_t              state_r;
    logic [SUM_W-1:0]    sum_r;
    logic [WIN_LOG2-1:0] cnt_r;
    logic [MISS_W-1:0]   miss_acc_r;
    logic                busy_r;
    logic                done_r;
    logic [POS_W-1:0]    min_pos_r;
    logic [POS_W-1:0]    max_pos_r;
    logic [POS_W-1:0]    p2p_r;
    logic [POS_W-1:0]    mean_pos_r;
    logic [MISS_W-1:0]   miss_cnt_r;

    logic                clear_s;
    logic                take_s;
    logic                valid_s;
    logic                miss_s;
    logic                last_s;
    logic [SUM_W-1:0]    sum_nxt_s;
    logic [POS_W-1:0]    min_nxt_s;
    logic [POS_W-1:0]    max_nxt_s;

    assign clear_s   = (state_r == ST_IDLE) && start && !abort;
    assign take_s    = (state_r == ST_ACCUM) && !abort && sample_en;
    assign valid_s   = take_s && (pos_in != POS_W'(NO_EDGE));
    assign miss_s    = take_s && (pos_in == POS_W'(NO_EDGE));
    assign last_s    = valid_s && (cnt_r == {WIN_LOG2{1'b1}});
    assign sum_nxt_s = sum_r + SUM_W'(pos_in);

    skitter_minmax_trk #(
        .POS_W (POS_W)
    ) u_minmax (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .upd     (valid_s),
        .pos     (pos_in),
        .min_nxt (min_nxt_s),
        .max_nxt (max_nxt_s)
    );

    // Window FSM, accumulators and result registers; results load on the
    // edge that accepts the last sample so they are valid alongside done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            sum_r      <= {SUM_W{1'b0}};
            cnt_r      <= {WIN_LOG2{1'b0}};
            miss_acc_r <= {MISS_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            min_pos_r  <= {POS_W{1'b0}};
            max_pos_r  <= {POS_W{1'b0}};
            p2p_r      <= {POS_W{1'b0}};
            mean_pos_r <= {POS_W{1'b0}};
            miss_cnt_r <= {MISS_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (clear_s) begin
                        state_r    <= ST_ACCUM;
                        busy_r     <= 1'b1;
                        sum_r      <= {SUM_W{1'b0}};
                        cnt_r      <= {WIN_LOG2{1'b0}};
                        miss_acc_r <= {MISS_W{1'b0}};
                    end
                end
                ST_ACCUM: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (valid_s) begin
                        sum_r <= sum_nxt_s;
                        cnt_r <= cnt_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
                        if (last_s) begin
                            state_r    <= ST_DONE;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            min_pos_r  <= min_nxt_s;
                            max_pos_r  <= max_nxt_s;
                            p2p_r      <= max_nxt_s - min_nxt_s;
                            mean_pos_r <= POS_W'(sum_nxt_s >> WIN_LOG2);
                            miss_cnt_r <= miss_acc_r;
                        end
                    end else if (miss_s && (miss_acc_r != {MISS_W{1'b1}})) begin
                        miss_acc_r <= miss_acc_r + {{(MISS_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SKITTER_STATS_SUMSQ_EN
    localparam int SQ_W = 2*POS_W + WIN_LOG2;

    logic [SQ_W-1:0] sumsq_acc_r;
    logic [SQ_W-1:0] sumsq_r;
    logic [SQ_W-1:0] sumsq_nxt_s;

    assign sumsq_nxt_s = sumsq_acc_r + SQ_W'(pos_in) * SQ_W'(pos_in);

    // Sum of squared positions, published with the other window results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sumsq_acc_r <= {SQ_W{1'b0}};
            sumsq_r     <= {SQ_W{1'b0}};
        end else if (clear_s) begin
            sumsq_acc_r <= {SQ_W{1'b0}};
        end else if (valid_s) begin
            sumsq_acc_r <= sumsq_nxt_s;
            if (last_s) begin
                sumsq_r <= sumsq_nxt_s;
            end
        end
    end

    assign sumsq = sumsq_r;
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign min_pos  = min_pos_r;
    assign max_pos  = max_pos_r;
    assign p2p      = p2p_r;
    assign mean_pos = mean_pos_r;
    assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_skitter_edge_stats.sv
// Self-checking bench for skitter_edge_stats: directed windows plus random
// traffic against a queue-based window model.
module tb_skitter_edge_stats;

    localparam int PW       = 6;
    localparam int WL       = 2;
    localparam int MW       = 2;
    localparam int WIN      = 1 << WL;
    localparam int MISS_MAX = (1 << MW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] pos_in = '0;
    logic          sample_en = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic [PW-1:0] min_pos;
    logic [PW-1:0] max_pos;
    logic [PW-1:0] p2p;
    logic [PW-1:0] mean_pos;
    logic [MW-1:0] miss_cnt;
`ifdef SKITTER_STATS_SUMSQ_EN
    logic [2*PW+WL-1:0] sumsq;
`endif

    skitter_edge_stats #(.POS_W(PW), .WIN_LOG2(WL), .MISS_W(MW)) dut (
        .clk(clk), .rst(rst), .pos_in(pos_in), .sample_en(sample_en),
        .start(start), .abort(abort), .busy(busy), .done(done),
        .min_pos(min_pos), .max_pos(max_pos), .p2p(p2p), .mean_pos(mean_pos),
`ifdef SKITTER_STATS_SUMSQ_EN
        .sumsq(sumsq),
`endif
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 accumulating, 2 done cycle
    int m_st = 0;
    int vals[$];
    int m_miss = 0;
    int e_min = 0, e_max = 0, e_mean = 0, e_miss = 0;
    longint e_sumsq = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic close_window();
        int s;
        s = 0;
        e_sumsq = 0;
        e_min = vals[0];
        e_max = vals[0];
        foreach (vals[i]) begin
            s += vals[i];
            e_sumsq += longint'(vals[i] * vals[i]);
            if (vals[i] < e_min) e_min = vals[i];
            if (vals[i] > e_max) e_max = vals[i];
        end
        e_mean = s / WIN;
        e_miss = m_miss;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_busy"}, busy, (m_st == 1));
        check_val({tag, "_done"}, done, (m_st == 2));
        check_val({tag, "_min"}, min_pos, e_min);
        check_val({tag, "_max"}, max_pos, e_max);
        check_val({tag, "_p2p"}, p2p, e_max - e_min);
        check_val({tag, "_mean"}, mean_pos, e_mean);
        check_val({tag, "_miss"}, miss_cnt, e_miss);
`ifdef SKITTER_STATS_SUMSQ_EN
        check_val({tag, "_sumsq"}, sumsq, e_sumsq);
`endif
    endtask

    task automatic cyc(input bit en, input int p, input bit st, input bit ab, input string tag);
        sample_en = en;
        pos_in    = PW'(p);
        start     = st;
        abort     = ab;
        @(posedge clk);
        #1;
        case (m_st)
            0: if (st && !ab) begin
                m_st = 1;
                vals.delete();
                m_miss = 0;
            end
            1: if (ab) begin
                m_st = 0;
            end else if (en) begin
                if (p == 0) begin
                    if (m_miss < MISS_MAX) m_miss++;
                end else begin
                    vals.push_back(p);
                    if (vals.size() == WIN) begin
                        m_st = 2;
                        close_window();
                    end
                end
            end
            default: m_st = 0;
        endcase
        sample_en = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        m_st = 0; vals.delete(); m_miss = 0;
        e_min = 0; e_max = 0; e_mean = 0; e_miss = 0; e_sumsq = 0;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int seq2[6];
        int seq4[4];
        seq2 = '{22, 0, 0, 22, 22, 22};
        seq4 = '{1, 2, 3, 4};

        repeat (2) @(posedge clk);
        async_reset("reset");

        cyc(0, 0, 1, 0, "t1_start");
        cyc(1, 20, 0, 0, "t1_s");
        cyc(1, 25, 0, 0, "t1_s");
        cyc(1, 18, 0, 0, "t1_s");
        cyc(1, 30, 0, 0, "t1_last");
        check_val("t1_done_const", done, 1);
        check_val("t1_min_const", min_pos, 18);
        check_val("t1_max_const", max_pos, 30);
        check_val("t1_p2p_const", p2p, 12);
        check_val("t1_mean_const", mean_pos, 23);
        check_val("t1_miss_const", miss_cnt, 0);
        cyc(0, 0, 0, 0, "t1_after");

        cyc(0, 0, 1, 0, "t2_start");
        foreach (seq2[i]) cyc(1, seq2[i], 0, 0, "t2_s");
        check_val("t2_done_const", done, 1);
        check_val("t2_p2p_const", p2p, 0);
        check_val("t2_mean_const", mean_pos, 22);
        check_val("t2_miss_const", miss_cnt, 2);
        cyc(0, 0, 0, 0, "t2_after");

        cyc(0, 0, 1, 0, "t3_start");
        repeat (5) cyc(1, 0, 0, 0, "t3_miss");
        cyc(0, 9, 0, 0, "t3_gap");
        repeat (4) cyc(1, 17, 0, 0, "t3_s");
        check_val("t3_miss_sat_const", miss_cnt, 3);
        check_val("t3_mean_const", mean_pos, 17);
        cyc(0, 0, 0, 0, "t3_after");

        cyc(0, 0, 1, 0, "t4_start");
        cyc(1, 20, 0, 0, "t4_s");
        cyc(1, 21, 0, 0, "t4_s");
        cyc(1, 5, 1, 1, "t4_abort");
        check_val("t4_busy_const", busy, 0);
        check_val("t4_mean_kept_const", mean_pos, 17);
        cyc(0, 0, 1, 1, "t4_start_abort");
        check_val("t4_stay_idle_const", busy, 0);
        cyc(1, 40, 0, 0, "t4_idle_sample");

        cyc(0, 0, 1, 0, "t5_start");
        cyc(1, 38, 0, 0, "t5_s");
        cyc(1, 38, 0, 0, "t5_s");
        async_reset("t5_rst");
        check_val("t5_min_const", min_pos, 0);

        cyc(0, 0, 1, 0, "t6_start");
        foreach (seq4[i]) cyc(1, seq4[i], 0, 0, "t6_s");
        check_val("t6_mean_const", mean_pos, 2);
        check_val("t6_p2p_const", p2p, 3);
`ifdef SKITTER_STATS_SUMSQ_EN
        check_val("t6_sumsq_const", sumsq, 30);
`endif
        cyc(1, 7, 1, 0, "t6_done_start_ignored");

        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset("rand_rst");
            cyc($urandom_range(0, 3) != 0,
                ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 63)),
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 39) == 0,
                "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
